alu_bist: RTL and testbench

Built-in self-test controller for the single-cycle CPU's combinational ALU. It acts as the initiator on the ALU's `a`/`b`/`aluc` → `r`/`z` interface. It drives pseudo-random operand pairs through every defined `aluc` code and compresses each `r`/`z` result into a 32-bit MISR signature. At the end of the run it compares the signature against a golden value and reports pass/fail through a start/done handshake.

---
 rtl/alu_bist.sv | 125 ++++++++++++
 tb/tb_alu_bist.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_bist.sv
// alu_bist: BIST controller for the combinational ALU.
// It drives pseudo-random operand pairs through every defined aluc code
// (0..10, 12..15) and folds each r/z result into a 32-bit MISR. At the end
// of the run it compares the MISR with GOLDEN.
// Optional feature macro: ALU_BIST_ZCHK_EN enables a sticky z-consistency check.
`timescale 1ns/1ps
module alu_bist #(
  parameter int          VECTORS = 4,
  parameter logic [31:0] SEED    = 32'h00ff00ff,
  parameter logic [31:0] GOLDEN  = 32'h00000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [31:0] signature,
  output logic        zerr,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_aluc,
  input  logic [31:0] alu_r,
  input  logic        alu_z
);

  typedef enum logic [1:0] {IDLE, APPLY, CAPTURE, DONE} state_t;

  localparam logic [31:0] SEED_EFF = (SEED == 32'h0) ? 32'h00000001 : SEED;
  localparam logic [7:0]  VEC_LAST = 8'(VECTORS - 1);
  localparam logic [3:0]  OP_LAST  = 4'd14;  // index of aluc 15

  // Shared LFSR / MISR shift-with-feedback
  function automatic logic [31:0] step(input logic [31:0] x);
    return {x[30:0], 1'b0} ^ (x[31] ? 32'h00400007 : 32'h0);
  endfunction

  state_t      state, state_nxt;
  logic [31:0] lfsr;
  logic [3:0]  op_idx;
  logic [7:0]  vec_cnt;
  logic [3:0]  op_code;
  logic        accept, last_vec, last_op;

  // Index 0..14 maps onto codes 0..10,12..15 so the reserved code 11 is skipped
  assign op_code  = (op_idx < 4'd11) ? op_idx : op_idx + 4'd1;
  assign last_vec = (vec_cnt == VEC_LAST);
  assign last_op  = (op_idx == OP_LAST);
  assign accept   = start && ((state == IDLE) || (state == DONE));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic: start only matters when idle or done
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (start) state_nxt = APPLY;
      APPLY:      state_nxt = CAPTURE;
      CAPTURE:    state_nxt = (last_vec && last_op) ? DONE : APPLY;
      default:    state_nxt = IDLE;
    endcase
  end

  // Datapath: operand generation, MISR compaction, counters and status
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr      <= 32'h0;
      signature <= 32'h0;
      op_idx    <= 4'd0;
      vec_cnt   <= 8'd0;
      alu_a     <= 32'h0;
      alu_b     <= 32'h0;
      alu_aluc  <= 4'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else if (accept) begin
      lfsr      <= SEED_EFF;
      signature <= 32'h0;
      op_idx    <= 4'd0;
      vec_cnt   <= 8'd0;
      busy      <= 1'b1;
      done      <= 1'b0;
    end else if (state == APPLY) begin
      alu_a    <= lfsr;
      alu_b    <= {lfsr[15:0], lfsr[31:16]};
      alu_aluc <= op_code;
      lfsr     <= step(lfsr);
    end else if (state == CAPTURE) begin
      signature <= step(signature) ^ alu_r ^ {31'b0, alu_z};
      if (last_vec) begin
        vec_cnt <= 8'd0;
        op_idx  <= last_op ? 4'd0 : op_idx + 4'd1;
        if (last_op) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end else begin
        vec_cnt <= vec_cnt + 8'd1;
      end
    end
  end

`ifdef ALU_BIST_ZCHK_EN
  logic zerr_q;

  // Sticky flag: zero flag disagrees with the result it accompanies
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                   zerr_q <= 1'b0;
    else if (accept)                              zerr_q <= 1'b0;
    else if (state == CAPTURE &&
             (alu_z != (alu_r == 32'h0)))         zerr_q <= 1'b1;
  end

  assign zerr = zerr_q;
`else
  assign zerr = 1'b0;
`endif

  assign pass = done && (signature == GOLDEN) && !zerr;

endmodule

// File: tb/tb_alu_bist.sv
// Testbench for alu_bist: two instances (seeded VECTORS=1 run and SEED=0 VECTORS=3 run)
// each driving a behavioural ALU, checked against a reference signature model.
`timescale 1ns/1ps
module tb_alu_bist;

  // Reference ALU behaviour used both to drive the DUT and in the model
  function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                         input logic [3:0] c);
    case (c)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return a & b;
      4'd3:  return a | b;
      4'd4:  return a ^ b;
      4'd5:  return ~(a | b);
      4'd6:  return {b[15:0], 16'h0};
      4'd7:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd8:  return (a < b) ? 32'd1 : 32'd0;
      4'd9:  return b << a[4:0];
      4'd10: return b >> a[4:0];
      4'd12: return 32'($signed(b) >>> a[4:0]);
      4'd13: return a;
      4'd14: return b;
      4'd15: return (a == b) ? 32'd0 : 32'd1;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] stepf(input logic [31:0] x);
    return {x[30:0], 1'b0} ^ (x[31] ? 32'h00400007 : 32'h0);
  endfunction

  // Expected signature of a full run; mode 0 clean, 1 r[0] stuck-at-0, 2 r=1/z=1
  function automatic logic [31:0] ref_sig(input logic [31:0] seed, input int vec,
                                          input int mode);
    logic [31:0] l, s, a, b, r;
    logic        z;
    l = (seed == 32'h0) ? 32'h1 : seed;
    s = 32'h0;
    for (int c = 0; c < 16; c++) begin
      if (c != 11) begin
        for (int v = 0; v < vec; v++) begin
          a = l;
          b = {a[15:0], a[31:16]};
          r = alu_fn(a, b, 4'(c));
          if (mode == 1) r[0] = 1'b0;
          z = (r == 32'h0);
          if (mode == 2) begin r = 32'h1; z = 1'b1; end
          s = stepf(s) ^ r ^ {31'b0, z};
          l = stepf(l);
        end
      end
    end
    return s;
  endfunction

  localparam int          VEC0  = 1;
  localparam int          VEC1  = 3;
  localparam logic [31:0] SEED0 = 32'h00ff00ff;
  localparam logic [31:0] SEED1 = 32'h00000000;
  localparam logic [31:0] GOLD0 = ref_sig(SEED0, VEC0, 0);
  localparam logic [31:0] GOLD1 = 32'h00000000;

`ifdef ALU_BIST_ZCHK_EN
  localparam bit ZCHK = 1'b1;
`else
  localparam bit ZCHK = 1'b0;
`endif

  logic        clk, rst_n;
  logic        start     [2];
  logic        busy      [2];
  logic        done      [2];
  logic        pass      [2];
  logic        zerr      [2];
  logic [31:0] signature [2];
  logic [31:0] alu_a     [2];
  logic [31:0] alu_b     [2];
  logic [3:0]  alu_aluc  [2];
  logic [31:0] alu_r     [2];
  logic        alu_z     [2];
  int          fmode     [2];

  int checks = 0;
  int failures = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALUs with optional fault injection
  always_comb begin
    for (int d = 0; d < 2; d++) begin
      alu_r[d] = alu_fn(alu_a[d], alu_b[d], alu_aluc[d]);
      if (fmode[d] == 1) alu_r[d][0] = 1'b0;
      alu_z[d] = (alu_r[d] == 32'h0);
      if (fmode[d] == 2) begin
        alu_r[d] = 32'h1;
        alu_z[d] = 1'b1;
      end
    end
  end

  alu_bist #(.VECTORS(VEC0), .SEED(SEED0), .GOLDEN(GOLD0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .busy(busy[0]), .done(done[0]),
    .pass(pass[0]), .signature(signature[0]), .zerr(zerr[0]), .alu_a(alu_a[0]),
    .alu_b(alu_b[0]), .alu_aluc(alu_aluc[0]), .alu_r(alu_r[0]), .alu_z(alu_z[0]));

  alu_bist #(.VECTORS(VEC1), .SEED(SEED1), .GOLDEN(GOLD1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .busy(busy[1]), .done(done[1]),
    .pass(pass[1]), .signature(signature[1]), .zerr(zerr[1]), .alu_a(alu_a[1]),
    .alu_b(alu_b[1]), .alu_aluc(alu_aluc[1]), .alu_r(alu_r[1]), .alu_z(alu_z[1]));

  function automatic bit all_zero(input int d);
    return !busy[d] && !done[d] && !pass[d] && !zerr[d] && signature[d] == 32'h0 &&
           alu_a[d] == 32'h0 && alu_b[d] == 32'h0 && alu_aluc[d] == 4'd0;
  endfunction

  // Full run on instance d: operand sequence, done timing, final status.
  // With hold=1, start stays high through the run and a restart from DONE is checked.
  task automatic run_check(input int d, input int mode, input bit hold, input string tag);
    int          vec;
    logic [31:0] seed, gold, l, esig;
    bit          seq_ok, early_ok, epass, ezerr;
    string       msg;
    vec  = (d == 0) ? VEC0 : VEC1;
    seed = (d == 0) ? SEED0 : SEED1;
    gold = (d == 0) ? GOLD0 : GOLD1;
    esig = ref_sig(seed, vec, mode);
    ezerr = ZCHK && (mode == 2);
    epass = (esig == gold) && !ezerr;
    fmode[d] = mode;
    repeat ($urandom_range(0, 3)) @(negedge clk);
    @(negedge clk); start[d] = 1'b1;
    @(posedge clk); #1;
    if (!hold) start[d] = 1'b0;
    checks++;
    if (busy[d] !== 1'b1 || done[d] !== 1'b0) begin
      failures++;
      $display("FAIL %s accept: busy=%b done=%b want busy=1 done=0", tag, busy[d], done[d]);
    end
    l = (seed == 32'h0) ? 32'h1 : seed;
    seq_ok = 1'b1; early_ok = 1'b1; msg = "";
    for (int c = 0; c < 16; c++) begin
      if (c != 11) begin
        for (int v = 0; v < vec; v++) begin
          @(posedge clk); #1;
          if (seq_ok && (alu_a[d] !== l || alu_b[d] !== {l[15:0], l[31:16]} ||
                         alu_aluc[d] !== 4'(c))) begin
            seq_ok = 1'b0;
            msg = $sformatf("a=%h b=%h c=%0d want a=%h b=%h c=%0d", alu_a[d], alu_b[d],
                            alu_aluc[d], l, {l[15:0], l[31:16]}, c);
          end
          if (done[d] !== 1'b0 || busy[d] !== 1'b1) early_ok = 1'b0;
          l = stepf(l);
          @(posedge clk);
        end
      end
    end
    #1;
    checks++;
    if (!seq_ok) begin
      failures++;
      $display("FAIL %s operand_seq: %s", tag, msg);
    end
    checks++;
    if (!early_ok) begin
      failures++;
      $display("FAIL %s run_busy: done/busy wrong before E0+%0d", tag, 30 * vec);
    end
    checks++;
    if (done[d] !== 1'b1 || busy[d] !== 1'b0) begin
      failures++;
      $display("FAIL %s done_edge: done=%b busy=%b want done=1 busy=0", tag, done[d], busy[d]);
    end
    checks++;
    if (signature[d] !== esig) begin
      failures++;
      $display("FAIL %s signature: got %h want %h", tag, signature[d], esig);
    end
    checks++;
    if (pass[d] !== epass || zerr[d] !== ezerr) begin
      failures++;
      $display("FAIL %s status: pass=%b zerr=%b want pass=%b zerr=%b", tag, pass[d],
               zerr[d], epass, ezerr);
    end
    if (hold) begin
      @(posedge clk); #1;
      start[d] = 1'b0;
      checks++;
      if (done[d] !== 1'b0 || busy[d] !== 1'b1) begin
        failures++;
        $display("FAIL %s restart: done=%b busy=%b want done=0 busy=1", tag, done[d], busy[d]);
      end
      repeat (30 * vec) @(posedge clk);
      #1;
      checks++;
      if (done[d] !== 1'b1 || signature[d] !== esig) begin
        failures++;
        $display("FAIL %s rerun: done=%b sig=%h want done=1 sig=%h", tag, done[d],
                 signature[d], esig);
      end
    end
    fmode[d] = 0;
  endtask

  task automatic test_reset();
    #1;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (!all_zero(d)) begin
        failures++;
        $display("FAIL reset_state dut%0d: busy=%b done=%b pass=%b zerr=%b sig=%h a=%h b=%h c=%0d want all 0",
                 d, busy[d], done[d], pass[d], zerr[d], signature[d], alu_a[d], alu_b[d], alu_aluc[d]);
      end
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    run_check(0, 0, 1'b0, "basic");
    // DONE holds status while idle
    repeat ($urandom_range(2, 6)) @(posedge clk);
    #1;
    checks++;
    if (done[0] !== 1'b1 || pass[0] !== 1'b1 || signature[0] !== GOLD0) begin
      failures++;
      $display("FAIL done_hold: done=%b pass=%b sig=%h want 1 1 %h", done[0], pass[0],
               signature[0], GOLD0);
    end
  endtask

  task automatic test_stuck_at();
    run_check(0, 1, 1'b0, "sa0");
    checks++;
    if (signature[0] === GOLD0 || pass[0] !== 1'b0) begin
      failures++;
      $display("FAIL sa0_detect: sig=%h pass=%b want sig!=%h pass=0", signature[0], pass[0], GOLD0);
    end
  endtask

  task automatic test_reset_midrun();
    @(negedge clk); start[0] = 1'b1;
    @(posedge clk); #1 start[0] = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (!all_zero(0)) begin
      failures++;
      $display("FAIL reset_midrun: busy=%b done=%b sig=%h a=%h b=%h c=%0d want all 0",
               busy[0], done[0], signature[0], alu_a[0], alu_b[0], alu_aluc[0]);
    end
    @(negedge clk); rst_n = 1'b1;
    run_check(0, 0, 1'b0, "after_reset");
  endtask

  task automatic test_start_held();
    run_check(0, 0, 1'b1, "start_held");
  endtask

  task automatic test_zcheck();
    run_check(0, 2, 1'b0, "zchk");
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (zerr[0] !== ZCHK) begin
      failures++;
      $display("FAIL zerr_sticky: zerr=%b want %b", zerr[0], ZCHK);
    end
  endtask

  task automatic test_seed0();
    run_check(1, 0, 1'b0, "seed0");
  endtask

  initial begin
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      start[d] = 1'b0;
      fmode[d] = 0;
    end
    test_reset();
    test_basic();
    test_stuck_at();
    test_reset_midrun();
    test_start_held();
    test_zcheck();
    test_basic();
    test_seed0();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time bound so a stuck run still ends
  initial begin
    #200000;
    $display("FAIL timeout: sim time exceeded bound");
    $fatal(1, "timeout");
  end

endmodule
